// File: rtl/rgb_cmd_pwm.sv
// rgb_cmd_pwm: SPI command decoder and 3-channel 8-bit PWM generator for the RGB LED stage.
//
// A parser decodes byte frames from the SPI slave. SET_RGB (R, G, B) loads new duties and
// SET_MODE sets test_mode. New duties are double-buffered: a full RGB triple is committed to
// a pending set, and the pending set is copied to the active set only at a PWM period
// boundary. This keeps each PWM period glitch-free.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_cs_n    SPI chip select (active-low, clk-synchronous); high ends or aborts a frame
//   rx_stb     one-cycle strobe: rx_data holds a complete received byte
//   rx_data    received byte
//   tx_data    byte to load for the next SPI transmit (8'h00 unless readback is built)
//   out_r/g/b  PWM bits for the LED stage (in_r/in_g/in_b)
//   test_mode  cycle-mode select for the LED stage; not used to gate the PWM outputs here
//
// Optional feature: define RGB_READBACK_EN to build CMD_GET_RGB. This command returns the
// active R, G and B duties on tx_data, one per received byte.
module rgb_cmd_pwm #(
  parameter int unsigned PRESCALE     = 64,
  parameter logic [7:0]  CMD_SET_RGB  = 8'h01,
  parameter logic [7:0]  CMD_SET_MODE = 8'h02,
  parameter logic [7:0]  CMD_GET_RGB  = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_cs_n,
  input  logic       rx_stb,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       out_r,
  output logic       out_g,
  output logic       out_b,
  output logic       test_mode
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetR,
    StGetG,
    StGetB,
    StGetMode,
`ifdef RGB_READBACK_EN
    StRdR,
    StRdG,
`endif
    StDrop
  } state_e;

  state_e          state_q;
  logic [7:0]      shadow_r_q, shadow_g_q;
  logic [7:0]      pend_r_q, pend_g_q, pend_b_q;
  logic            pend_flag_q;
  logic [7:0]      act_r_q, act_g_q, act_b_q;
  logic [PreW-1:0] pre_q;
  logic [7:0]      cnt_q;
  logic            tick, period_end, byte_ok, commit;

  assign tick       = (pre_q == PreMax);
  assign period_end = tick && (cnt_q == 8'd254);
  assign byte_ok    = rx_stb && !rx_cs_n;
  // The blue byte goes straight into the pending set, so no blue shadow register is needed.
  assign commit     = byte_ok && (state_q == StGetB);

`ifdef RGB_READBACK_EN
  logic [7:0] tx_q;
  assign tx_data = tx_q;
`else
  assign tx_data = 8'h00;
`endif

  // Command parser
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shadow_r_q <= 8'h00;
      shadow_g_q <= 8'h00;
      test_mode  <= 1'b0;
`ifdef RGB_READBACK_EN
      tx_q       <= 8'h00;
`endif
    end else if (rx_cs_n) begin
      state_q <= StIdle;
`ifdef RGB_READBACK_EN
      tx_q    <= 8'h00;
`endif
    end else if (rx_stb) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == CMD_SET_RGB) begin
            state_q <= StGetR;
          end else if (rx_data == CMD_SET_MODE) begin
            state_q <= StGetMode;
`ifdef RGB_READBACK_EN
          end else if (rx_data == CMD_GET_RGB) begin
            tx_q    <= act_r_q;
            state_q <= StRdR;
`else
          end else if (rx_data == CMD_GET_RGB) begin
            state_q <= StDrop;  // readback not built: treated as unknown
`endif
          end else begin
            state_q <= StDrop;
          end
        end
        StGetR: begin
          shadow_r_q <= rx_data;
          state_q    <= StGetG;
        end
        StGetG: begin
          shadow_g_q <= rx_data;
          state_q    <= StGetB;
        end
        StGetB:    state_q <= StDrop;
        StGetMode: begin
          test_mode <= rx_data[0];
          state_q   <= StDrop;
        end
`ifdef RGB_READBACK_EN
        StRdR: begin
          tx_q    <= act_g_q;
          state_q <= StRdG;
        end
        StRdG: begin
          tx_q    <= act_b_q;
          state_q <= StDrop;
        end
`endif
        StDrop:  state_q <= StDrop;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Duty double-buffer. A commit on the same edge as a period end overrides the flag clear,
  // so the fresh triple stays pending for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r_q    <= 8'h00;
      pend_g_q    <= 8'h00;
      pend_b_q    <= 8'h00;
      pend_flag_q <= 1'b0;
      act_r_q     <= 8'h00;
      act_g_q     <= 8'h00;
      act_b_q     <= 8'h00;
    end else begin
      if (period_end && pend_flag_q) begin
        act_r_q     <= pend_r_q;
        act_g_q     <= pend_g_q;
        act_b_q     <= pend_b_q;
        pend_flag_q <= 1'b0;
      end
      if (commit) begin
        pend_r_q    <= shadow_r_q;
        pend_g_q    <= shadow_g_q;
        pend_b_q    <= rx_data;
        pend_flag_q <= 1'b1;
      end
    end
  end

  // Prescaler, 255-step PWM counter and registered compare
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= 8'h00;
      out_r <= 1'b0;
      out_g <= 1'b0;
      out_b <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        cnt_q <= (cnt_q == 8'd254) ? 8'h00 : cnt_q + 8'd1;
      end
      out_r <= (cnt_q < act_r_q);
      out_g <= (cnt_q < act_g_q);
      out_b <= (cnt_q < act_b_q);
    end
  end

endmodule

// File: tb/tb_rgb_cmd_pwm.sv
// tb_rgb_cmd_pwm: randomized scoreboard bench for rgb_cmd_pwm (PRESCALE=1).
// A behavioural model tracks frames as byte lists and time as a cycle count. It pushes the
// expected outputs for every clock edge into a queue. A monitor pops them on the falling edge.
module tb_rgb_cmd_pwm;
  localparam int unsigned P      = 1;
  localparam int unsigned PERIOD = 255 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_cs_n = 1'b1;
  logic       rx_stb = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       out_r, out_g, out_b, test_mode;

  rgb_cmd_pwm #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_cs_n   (rx_cs_n),
    .rx_stb    (rx_stb),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .test_mode (test_mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rgb;
    logic       tm;
    logic [7:0] tx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
  endtask

  // ---------------- reference model ----------------
  int unsigned t;              // cycle index since reset release
  int          m_act[3];
  int          m_pend[3];
  bit          m_pflag;
  bit          m_tm;
  logic [7:0]  m_tx;
  logic [7:0]  frame[$];
  int          m_cnt;
  bit          m_commit;
  int          m_new[3];
  exp_t        m_e;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_pflag = 0;
      m_tm = 0;
      m_tx = 8'h00;
      frame.delete();
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 0;
        m_pend[i] = 0;
      end
      exp_q.push_back('0);
    end else begin
      m_cnt = (t / P) % 255;
      m_e.rgb = {m_cnt < m_act[0], m_cnt < m_act[1], m_cnt < m_act[2]};
      m_commit = 0;
      if (rx_cs_n) begin
        frame.delete();
        m_tx = 8'h00;
      end else if (rx_stb) begin
        frame.push_back(rx_data);
        if (frame[0] == 8'h01 && frame.size() == 4) begin
          m_commit = 1;
          for (int i = 0; i < 3; i++) m_new[i] = frame[i+1];
        end
        if (frame[0] == 8'h02 && frame.size() == 2) m_tm = rx_data[0];
`ifdef RGB_READBACK_EN
        if (frame[0] == 8'h03 && frame.size() <= 3) m_tx = 8'(m_act[frame.size()-1]);
`endif
      end
      if ((t % PERIOD) == PERIOD - 1 && m_pflag) begin
        m_act = m_pend;
        m_pflag = 0;
      end
      if (m_commit) begin
        m_pend = m_new;
        m_pflag = 1;
      end
      m_e.tm = m_tm;
      m_e.tx = m_tx;
      exp_q.push_back(m_e);
      t++;
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pwm_rgb", {5'b0, out_r, out_g, out_b}, {5'b0, mon_e.rgb});
      chk("test_mode", {7'b0, test_mode}, {7'b0, mon_e.tm});
      chk("tx_data", tx_data, mon_e.tx);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_stb = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_stb = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    rx_cs_n = 1'b0;
  endtask

  task automatic frame_end();
    @(negedge clk);
    rx_cs_n = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b[4];
    b = '{b0, b1, b2, b3};
    frame_begin();
    for (int i = 0; i < n; i++) send_byte(b[i]);
    frame_end();
  endtask

  // High-cycle counts over any 255 consecutive cycles equal the duty when PRESCALE=1.
  task automatic check_duty(input string tag, input int wr, input int wg, input int wb);
    int cr, cg, cb;
    cr = 0; cg = 0; cb = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      cr += int'(out_r);
      cg += int'(out_g);
      cb += int'(out_b);
    end
    chk({tag, "_r_high"}, 8'(cr), 8'(wr));
    chk({tag, "_g_high"}, 8'(cg), 8'(wg));
    chk({tag, "_b_high"}, 8'(cb), 8'(wb));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing may light up
    repeat (600) @(negedge clk);
    chk("idle_outs", {4'b0, out_r, out_g, out_b, test_mode}, 8'h00);

    // Basic SET_RGB
    send_frame(4, 8'h01, 8'h80, 8'h40, 8'hFF);
    repeat (2 * PERIOD) @(negedge clk);
    check_duty("set1", 128, 64, 255);

    // Aborted SET_RGB commits nothing, then a full one applies
    send_frame(3, 8'h01, 8'h11, 8'h22, 8'h00);
    repeat (2 * PERIOD) @(negedge clk);
    check_duty("abort", 128, 64, 255);
    send_frame(4, 8'h01, 8'h10, 8'h20, 8'h30);
    repeat (2 * PERIOD) @(negedge clk);
    check_duty("set2", 16, 32, 48);

    // test_mode control and unknown opcode
    send_frame(2, 8'h02, 8'h01, 8'h00, 8'h00);
    send_frame(2, 8'h02, 8'h00, 8'h00, 8'h00);
    send_frame(2, 8'h02, 8'h01, 8'h00, 8'h00);
    send_frame(2, 8'h05, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("test_mode_hold", {7'b0, test_mode}, 8'h01);

    // Third RGB byte strobed exactly on the period-end cycle
    frame_begin();
    send_byte(8'h01);
    send_byte(8'hC8);
    send_byte(8'h05);
    while ((t % PERIOD) != PERIOD - 1) @(negedge clk);
    rx_stb = 1'b1;
    rx_data = 8'h64;
    @(negedge clk);
    rx_stb = 1'b0;
    frame_end();
    check_duty("edge_old", 16, 32, 48);
    repeat (PERIOD) @(negedge clk);
    check_duty("edge_new", 200, 5, 100);

    // Readback (tx_data expectations come from the model; stays 00 when not built)
    send_frame(4, 8'h01, 8'hAA, 8'h55, 8'h0F);
    repeat (2 * PERIOD) @(negedge clk);
    send_frame(3, 8'h03, 8'h12, 8'h34, 8'h00);

    // Randomized frames, stray strobes and mid-frame resets
    for (int k = 0; k < 30; k++) begin
      int n;
      logic [7:0] op;
      n = $urandom_range(0, 5);
      case ($urandom_range(0, 3))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        default: op = 8'($urandom);
      endcase
      frame_begin();
      if (n > 0) send_byte(op);
      for (int i = 1; i < n; i++) send_byte(8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      frame_end();
      if ($urandom_range(0, 3) == 0) begin
        rx_stb = 1'b1;
        rx_data = 8'h01;
        @(negedge clk);
        rx_stb = 1'b0;
      end
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    repeat (2 * PERIOD) @(negedge clk);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rgb_cmd_pwm.md
Name: rgb_cmd_pwm

Overview:
- Decodes the byte stream from the SPI slave into per-channel 8-bit duty values.
- Generates the on/off PWM bits that feed the RGB LED output stage, which consumes them as its in_r/in_g/in_b inputs.
- Also produces the stage's test_mode select.
- New duty values are double-buffered and applied only at PWM period boundaries, so there are no glitches mid-period.

Parameters:
- PRESCALE, 64, clk cycles per PWM step (>=1); PWM period = 255*PRESCALE clk.
- CMD_SET_RGB, 8'h01, opcode: three data bytes follow, R then G then B.
- CMD_SET_MODE, 8'h02, opcode: one data byte follows; bit0 is test_mode.
- CMD_GET_RGB, 8'h03, opcode: readback (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- rx_cs_n  in  1  SPI chip select, active-low, synchronous to clk; high means no frame
- rx_stb  in  1  one-cycle strobe: rx_data holds a complete received byte
- rx_data  in  8  received byte
- tx_data  out  8  byte to load for the next SPI transmit
- out_r  out  1  red PWM bit
- out_g  out  1  green PWM bit
- out_b  out  1  blue PWM bit
- test_mode  out  1  cycle-mode select for the LED stage

Behaviour:
- Reset values: out_r/out_g/out_b=0, test_mode=0, tx_data=8'h00.
  - Active and shadow duties = 0, pending=0, prescaler and PWM counter = 0, FSM=IDLE.
  - rst mid-frame aborts the frame and discards all partial data.
- Parser FSM: states IDLE, GET_R, GET_G, GET_B, GET_MODE, RD_R, RD_G, DROP.
  - Only rx_stb with rx_cs_n=0 advances the FSM.
  - IDLE: on a byte, CMD_SET_RGB->GET_R, CMD_SET_MODE->GET_MODE, any other opcode->DROP.
  - GET_R stores shadow_r and goes to GET_G.
  - GET_G stores shadow_g and goes to GET_B.
  - GET_B stores shadow_b, commits, and goes to DROP.
  - Commit: pending_{r,g,b} <= shadow, pend_flag <= 1.
  - GET_MODE: test_mode <= rx_data[0] on the same edge, then DROP.
  - DROP ignores bytes until the frame ends.
  - rx_cs_n=1 in any state forces IDLE next cycle. A SET_RGB aborted before its third byte commits nothing.
  - One command per frame; extra bytes are dropped.
- PWM timing:
  - The prescaler counts 0..PRESCALE-1; tick=1 when it wraps.
  - The PWM counter cnt counts 0..254 and advances on tick, wrapping 254->0.
  - Period end = tick && cnt==254.
- Duty update: at period end, if pend_flag, active duties <= pending and pend_flag <= 0.
  - If a commit lands on the same cycle as a period end: the old pending (if flagged) is applied, the new value stays pending with pend_flag=1, and it applies at the next boundary.
- Output compare: out_x <= (cnt < active_x), registered with 1 clk latency.
  - duty 0 gives constant 0; duty 255 gives constant 1; duty N is high for N of 255 steps.
- test_mode is register-only. The block does not gate its PWM outputs with it.

Optional Feature:
- Macro: RGB_READBACK_EN.
- With the macro:
  - CMD_GET_RGB in IDLE sets tx_data <= active_r and goes to RD_R.
  - The next byte sets tx_data <= active_g and goes to RD_G.
  - The next byte sets tx_data <= active_b and goes to DROP.
  - Incoming data bytes during readback are ignored.
  - tx_data returns to 8'h00 when rx_cs_n=1.
- Without the macro: CMD_GET_RGB goes to DROP like any unknown opcode, tx_data is a constant 8'h00, and the RD_* states are absent.

Test Plan:
- Reset with PRESCALE=1 -> all outputs 0; after 600 clk out_r/out_g/out_b still 0 and test_mode=0.
- Frame 01,80,40,FF, then wait 2 periods -> out_r high 128 of 255 clk per period, out_g 64/255, out_b constant 1. New values take effect only from the first cnt=0 after the commit.
- Frame 01,80,40 then rx_cs_n=1 -> no change in duties; a following frame 01,10,20,30 applies 16/32/48.
- Frame 02,01 -> test_mode=1 the cycle after the 2nd strobe; frame 02,00 -> 0. Frame 05,01 -> no change.
- Third SET_RGB byte strobed on the exact period-end cycle -> the previous duty runs one more full period, then the new duty applies; pend_flag clears.
- With RGB_READBACK_EN, after duties AA/55/0F: frame 03,xx,xx -> tx_data=AA after the 1st strobe, 55 after the 2nd, 0F after the 3rd, and 00 after rx_cs_n rises. Without the macro, tx_data stays 00.
